// File: rtl/rr_reader.sv
// Round-robin reader: arbitrates four FIFOs, strobes one read per cycle and
// forwards the returned word two cycles later, flagging any valid/strobe mismatch.

module rr_reader_lane #(
  parameter int             IW  = 2,
  parameter logic [IW-1:0]  IDX = '0
) (
  input  logic          i_pend,
  input  logic [IW-1:0] i_pidx,
  input  logic          i_valid,
  output logic          o_hit,
  output logic          o_stray
);
  logic w_mine;

  assign w_mine  = i_pend && (i_pidx == IDX);
  assign o_hit   = w_mine & i_valid;
  assign o_stray = ~w_mine & i_valid;
endmodule

module rr_reader #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_FIFO   = 4
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic [NUM_FIFO-1:0]   fifo_empty,
  input  logic [NUM_FIFO-1:0]   fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic [DATA_WIDTH-1:0] fifo_data2,
  input  logic [DATA_WIDTH-1:0] fifo_data3,
  input  logic                  dest_pause,
  output logic [NUM_FIFO-1:0]   fifo_rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            dest_sel,
  output logic                  err_rd,
  output logic                  idle
);
  localparam int IW = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]                          r_state;
  logic [IW-1:0]                       r_last;
  logic                                r_pend;
  logic [IW-1:0]                       r_pidx;
  logic                                r_ign;
  logic [DATA_WIDTH-1:0]               r_data;
  logic                                r_vld;
  logic [IW-1:0]                       r_dsel;
  logic                                r_err;
  logic                                r_idle;

  logic [NUM_FIFO-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_FIFO-1:0]                 w_hit_v;
  logic [NUM_FIFO-1:0]                 w_stray_v;
  logic [IW-1:0]                       w_cand;
  logic [IW-1:0]                       w_idx;
  logic                                w_found;
  logic                                w_any;
  logic                                w_gnt;
  logic                                w_hit;
  logic                                w_miss;
  logic                                w_err;
  logic [1:0]                          w_nxt;

  assign w_data = {fifo_data3, fifo_data2, fifo_data1, fifo_data0};
  assign w_any  = ~&fifo_empty;

  // Search starts one past the last grant; the last grantee is tried last,
  // so it only wins back-to-back when nothing else is waiting.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= NUM_FIFO; k++) begin
      w_cand = r_last + IW'(k);
      if (!w_found && !fifo_empty[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // Reads are allowed from every state once pause is low; reset gates the strobe.
  assign w_gnt   = RESET_L && !dest_pause && w_found;
  assign fifo_rd = w_gnt ? (NUM_FIFO'(1) << w_idx) : '0;

  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_lane
    rr_reader_lane #(
      .IW  (IW),
      .IDX (IW'(g))
    ) u_lane (
      .i_pend  (r_pend),
      .i_pidx  (r_pidx),
      .i_valid (fifo_valid[g]),
      .o_hit   (w_hit_v[g]),
      .o_stray (w_stray_v[g])
    );
  end

  assign w_hit  = |w_hit_v;
  assign w_miss = r_pend && !w_hit;
  // Stray valids right after reset belong to reads that reset already discarded.
  assign w_err  = w_miss || ((|w_stray_v) && !r_ign);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any && !dest_pause) w_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (dest_pause)              w_nxt = S_HOLD;
        else if (!w_any && !r_pend)  w_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (!dest_pause) begin
          if (w_any)        w_nxt = S_ACTIVE;
          else if (!r_pend) w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
      r_idle  <= 1'b1;
      r_last  <= IW'(NUM_FIFO - 1);
      r_pend  <= 1'b0;
      r_pidx  <= '0;
      r_ign   <= 1'b1;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_dsel  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_idle  <= (w_nxt == S_IDLE);
      r_ign   <= 1'b0;
      r_pend  <= w_gnt;
      if (w_gnt) begin
        r_pidx <= w_idx;
        r_last <= w_idx;
      end
      r_vld <= w_hit;
      if (w_hit) begin
        r_data <= w_data[r_pidx];
        r_dsel <= r_pidx;
      end
      if (w_err) r_err <= 1'b1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_vld;
  assign dest_sel  = r_dsel;
  assign err_rd    = r_err;
  assign idle      = r_idle;
endmodule

// File: tb/tb_rr_reader.sv
// Scoreboard bench for rr_reader: FIFO model feeds words, expected words are
// queued at read time and matched against data_out/dest_sel.

module tb_rr_reader;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          RESET_L = 1'b0;
  logic [3:0]    fifo_empty = 4'hF;
  logic [3:0]    fifo_valid = 4'h0;
  logic [DW-1:0] fd [4];
  logic          dest_pause = 1'b0;
  logic [3:0]    fifo_rd;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [1:0]    dest_sel;
  logic          err_rd;
  logic          idle;

  logic [DW-1:0] fq [4][$];
  logic [7:0]    sb [$];
  int gq [$];
  int dq [$];
  int gcyc [$];
  int vcyc [$];
  int cyc = 0, n_chk = 0, n_pass = 0, vcnt = 0;
  int drop_req = 0, skip_req = 0, inj_id = 0;
  logic [3:0] inj_v = 4'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_reader #(.DATA_WIDTH(DW), .NUM_FIFO(4)) dut (
    .clk        (clk),
    .RESET_L    (RESET_L),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_data0 (fd[0]),
    .fifo_data1 (fd[1]),
    .fifo_data2 (fd[2]),
    .fifo_data3 (fd[3]),
    .dest_pause (dest_pause),
    .fifo_rd    (fifo_rd),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .dest_sel   (dest_sel),
    .err_rd     (err_rd),
    .idle       (idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // FIFO model: registered read data one cycle after the strobe.
  initial begin : fifo_model
    logic [3:0]    rd_s;
    logic [DW-1:0] w;
    int drop_done, skip_done, inj_done;
    drop_done = 0; skip_done = 0; inj_done = 0;
    for (int i = 0; i < 4; i++) fd[i] = '0;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
      #1;
      rd_s = fifo_rd;
      if (rd_s != 4'b0) begin
        chk("rd_onehot", 32'($onehot(rd_s)), 1);
        chk("rd_legal", 32'(((rd_s & fifo_empty) == 4'b0) && !dest_pause && RESET_L), 1);
        gq.push_back(oh2i(rd_s));
        gcyc.push_back(cyc);
      end
      @(posedge clk); #1;
      fifo_valid = 4'b0;
      if (inj_id != inj_done) begin
        fifo_valid = inj_v;
        inj_done   = inj_id;
      end
      for (int i = 0; i < 4; i++) begin
        if (rd_s[i] && fq[i].size() != 0) begin
          w = fq[i].pop_front();
          if (drop_req != drop_done) drop_done++;
          else begin
            fifo_valid[i] = 1'b1;
            fd[i] = w;
            if (skip_req != skip_done) skip_done++;
            else sb.push_back({2'(i), w});
          end
        end
      end
      for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
    end
  end

  always @(negedge clk) begin
    #1;
    if (valid_out === 1'b1) begin
      vcnt++;
      dq.push_back(int'(dest_sel));
      vcyc.push_back(cyc);
      if (sb.size() == 0) chk("sb_underflow", 32'(dest_sel), 32'hFFFF);
      else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("data", 32'(data_out), 32'(e[5:0]));
        chk("dest", 32'(dest_sel), 32'(e[7:6]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int i, input logic [DW-1:0] w);
    fq[i].push_back(w);
  endtask

  task automatic do_reset(input int n);
    RESET_L = 1'b0;
    tick(n);
    RESET_L = 1'b1;
    tick(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && !(fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 &&
                        fq[3].size() == 0 && sb.size() == 0 && idle === 1'b1)) begin
      tick(1);
      n++;
    end
    chk("drain", 32'(n < 300), 1);
    tick(3);
  endtask

  task automatic chk_seq(input string tag, input int base, input int q[$], input int e[$]);
    chk({tag, "_len"}, 32'(q.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size() && base + i < q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(q[base + i]), 32'(e[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, db, vb;
    int e[$];
    // reset state
    RESET_L = 1'b0;
    tick(3);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_dest", 32'(dest_sel), 0);
    chk("rst_err", 32'(err_rd), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_rd", 32'(fifo_rd), 0);
    RESET_L = 1'b1;
    tick(2);

    // only FIFO 2 holds words: back-to-back strobes, 2-cycle latency
    gb = gq.size(); db = dq.size();
    load(2, 6'h11); load(2, 6'h22); load(2, 6'h33);
    drain();
    e = '{2, 2, 2};
    chk_seq("a_gnt", gb, gq, e);
    chk_seq("a_dst", db, dq, e);
    if (gcyc.size() >= gb + 3 && vcyc.size() >= db + 3) begin
      chk("a_lat", 32'(vcyc[db] - gcyc[gb]), 2);
      chk("a_gap1", 32'(gcyc[gb+1] - gcyc[gb]), 1);
      chk("a_gap2", 32'(gcyc[gb+2] - gcyc[gb+1]), 1);
      chk("a_vgap", 32'(vcyc[db+2] - vcyc[db]), 2);
    end else chk("a_cnt", 32'(gcyc.size() - gb), 3);
    chk("a_hold_data", 32'(data_out), 32'h33);
    chk("a_hold_dest", 32'(dest_sel), 2);
    chk("a_novalid", 32'(valid_out), 0);
    chk("a_err", 32'(err_rd), 0);

    // all four busy: strict rotation from index 0
    do_reset(2);
    gb = gq.size(); db = dq.size();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) load(i, 6'(i * 8 + k + 1));
    drain();
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("b_gnt", gb, gq, e);
    chk_seq("b_dst", db, dq, e);

    // pause right after a grant: in-flight word completes, rotation resumes
    do_reset(2);
    gb = gq.size(); db = dq.size();
    for (int i = 0; i < 3; i++) begin
      load(i, 6'(6'h20 + i)); load(i, 6'(6'h28 + i));
    end
    tick(1);
    dest_pause = 1'b1;
    tick(4);
    chk("c_paused_gnts", 32'(gq.size() - gb), 1);
    chk("c_inflight", 32'(dq.size() - db), 1);
    chk("c_hold_idle", 32'(idle), 0);
    dest_pause = 1'b0;
    drain();
    e = '{0, 1, 2, 0, 1, 2};
    chk_seq("c_gnt", gb, gq, e);
    chk_seq("c_dst", db, dq, e);

    // missing read-data valid: sticky error, no output
    do_reset(2);
    vb = vcnt;
    drop_req++;
    load(1, 6'h15);
    tick(1);
    chk("d_err_early", 32'(err_rd), 0);
    tick(1);
    chk("d_err_set", 32'(err_rd), 1);
    chk("d_novalid", 32'(vcnt - vb), 0);
    tick(8);
    chk("d_err_sticky", 32'(err_rd), 1);
    RESET_L = 1'b0;
    tick(1);
    chk("d_err_clr", 32'(err_rd), 0);
    RESET_L = 1'b1;
    tick(2);

    // spurious valid while idle
    vb = vcnt;
    inj_v = 4'b1000; inj_id++;
    tick(3);
    chk("e_err", 32'(err_rd), 1);
    chk("e_novalid", 32'(vcnt - vb), 0);
    chk("e_valid", 32'(valid_out), 0);

    // reset one cycle after a grant discards the read
    do_reset(2);
    gb = gq.size(); db = dq.size(); vb = vcnt;
    load(1, 6'h31); load(3, 6'h33);
    skip_req++;
    tick(1);
    RESET_L = 1'b0;
    load(0, 6'h30); load(2, 6'h32);
    tick(1);
    chk("f_valid", 32'(valid_out), 0);
    chk("f_idle", 32'(idle), 1);
    chk("f_data", 32'(data_out), 0);
    chk("f_dest", 32'(dest_sel), 0);
    chk("f_err", 32'(err_rd), 0);
    chk("f_rd", 32'(fifo_rd), 0);
    inj_v = 4'b0010; inj_id++;
    tick(1);
    RESET_L = 1'b1;
    drain();
    e = '{1, 0, 2, 3};
    chk_seq("f_gnt", gb, gq, e);
    e = '{0, 2, 3};
    chk_seq("f_dst", db, dq, e);
    chk("f_err_after", 32'(err_rd), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
